// File: rtl/uart_inst_loader.sv
// uart_inst_loader: 8N1 UART receiver that packs bytes little-endian into 32-bit
// words and writes them to instruction memory, holding the core in reset until done.
// Optional idle-timeout completion: define INST_LOADER_TIMEOUT_EN.
module uart_inst_loader #(
  parameter int unsigned CLKS_PER_BIT      = 10417,
  parameter logic [31:0] BASE_ADDR         = 32'h0000_0000,
  parameter int unsigned IDLE_TIMEOUT_BITS = 64
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        uart_rx_i,
  input  logic        load_en_i,
  output logic        mem_req_o,
  input  logic        mem_gnt_i,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  output logic [15:0] word_count_o,
  output logic        frame_err_o,
  output logic        overrun_o,
  output logic        load_done_o,
  output logic        core_rst_no
);
  localparam int unsigned TW = $clog2(CLKS_PER_BIT + 1);
  localparam logic [TW-1:0] BIT_END  = TW'(CLKS_PER_BIT - 1);
  localparam logic [TW-1:0] HALF_END = TW'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t        state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [2:0]    bit_idx_q, bit_idx_d;
  logic [7:0]    shift_q, shift_d;
  logic [1:0]    byte_idx_q, byte_idx_d;
  logic [31:0]   word_buf_q, word_buf_d;
  logic          rx_s1_q, rx_s1_d, rx_s2_q, rx_s2_d, rx_s3_q, rx_s3_d;
  logic          req_q, req_d;
  logic [31:0]   addr_q, addr_d, wdata_q, wdata_d;
  logic [15:0]   count_q, count_d;
  logic          frame_err_q, frame_err_d, overrun_q, overrun_d, done_q, done_d;
  logic          byte_ok;
  logic          timeout;

`ifdef INST_LOADER_TIMEOUT_EN
  localparam int unsigned TO_CYC = IDLE_TIMEOUT_BITS * CLKS_PER_BIT;
  localparam int unsigned IW = $clog2(TO_CYC + 1);
  localparam logic [IW-1:0] TO_END = IW'(TO_CYC);
  logic [IW-1:0] idle_q, idle_d;

  // Count consecutive high-line cycles in IDLE, saturating at the timeout length.
  always_comb begin
    idle_d = (load_en_i && state_q == IDLE && rx_s2_q) ? ((idle_q == TO_END) ? idle_q : idle_q + 1'b1) : '0;
    timeout = (idle_q == TO_END) && (count_q != 16'd0) && (byte_idx_q == 2'd0) && !req_q;
  end

  // Idle timer register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) idle_q <= '0;
    else         idle_q <= idle_d;
  end
`else
  assign timeout = 1'b0;
`endif

  // Next-state logic: RX bit FSM, word assembly, memory handshake and load completion.
  always_comb begin
    rx_s1_d     = uart_rx_i;
    rx_s2_d     = rx_s1_q;
    rx_s3_d     = rx_s2_q;
    state_d     = state_q;
    timer_d     = timer_q + 1'b1;
    bit_idx_d   = bit_idx_q;
    shift_d     = shift_q;
    byte_idx_d  = byte_idx_q;
    word_buf_d  = word_buf_q;
    req_d       = req_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    count_d     = count_q;
    frame_err_d = 1'b0;
    overrun_d   = overrun_q;
    done_d      = done_q;
    byte_ok     = 1'b0;
    if (!load_en_i) begin
      state_d    = IDLE;
      timer_d    = '0;
      byte_idx_d = 2'd0;
    end else begin
      case (state_q)
        IDLE: begin
          timer_d = '0;
          if (rx_s3_q && !rx_s2_q) state_d = START;
        end
        START: if (timer_q == HALF_END) begin
          timer_d   = '0;
          bit_idx_d = 3'd0;
          state_d   = rx_s2_q ? IDLE : DATA;
        end
        DATA: if (timer_q == BIT_END) begin
          timer_d   = '0;
          shift_d   = {rx_s2_q, shift_q[7:1]};
          bit_idx_d = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'd7) state_d = STOP;
        end
        STOP: if (timer_q == BIT_END) begin
          timer_d     = '0;
          state_d     = IDLE;
          byte_ok     = rx_s2_q;
          frame_err_d = !rx_s2_q;
        end
        default: state_d = IDLE;
      endcase
    end
    if (byte_ok) begin
      byte_idx_d = byte_idx_q + 2'd1;
      word_buf_d[{byte_idx_q, 3'b000} +: 8] = shift_q;
      if (byte_idx_q == 2'd3) begin
        if (req_q) overrun_d = 1'b1;
        else begin
          req_d   = 1'b1;
          wdata_d = {shift_q, word_buf_q[23:0]};
        end
      end
    end
    if (req_q && mem_gnt_i) begin
      req_d   = 1'b0;
      addr_d  = addr_q + 32'd4;
      count_d = count_q + 16'd1;
    end
    if ((!load_en_i && !req_q) || timeout) done_d = 1'b1;
  end

  // State and output registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rx_s1_q     <= 1'b1;
      rx_s2_q     <= 1'b1;
      rx_s3_q     <= 1'b1;
      state_q     <= IDLE;
      timer_q     <= '0;
      bit_idx_q   <= 3'd0;
      shift_q     <= 8'd0;
      byte_idx_q  <= 2'd0;
      word_buf_q  <= 32'd0;
      req_q       <= 1'b0;
      addr_q      <= BASE_ADDR;
      wdata_q     <= 32'd0;
      count_q     <= 16'd0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      rx_s1_q     <= rx_s1_d;
      rx_s2_q     <= rx_s2_d;
      rx_s3_q     <= rx_s3_d;
      state_q     <= state_d;
      timer_q     <= timer_d;
      bit_idx_q   <= bit_idx_d;
      shift_q     <= shift_d;
      byte_idx_q  <= byte_idx_d;
      word_buf_q  <= word_buf_d;
      req_q       <= req_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      count_q     <= count_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
      done_q      <= done_d;
    end
  end

  assign mem_req_o    = req_q;
  assign mem_addr_o   = addr_q;
  assign mem_wdata_o  = wdata_q;
  assign word_count_o = count_q;
  assign frame_err_o  = frame_err_q;
  assign overrun_o    = overrun_q;
  assign load_done_o  = done_q;
  assign core_rst_no  = done_q;
endmodule

// File: tb/tb_uart_inst_loader.sv
// tb_uart_inst_loader: table-driven word loads with a write scoreboard plus frame, glitch, overrun, reset and completion sequences.
module tb_uart_inst_loader;
  localparam int CPB = 16;

  logic        clk_i = 1'b0, rst_ni = 1'b0, uart_rx_i = 1'b1, load_en_i = 1'b1, mem_gnt_i = 1'b0;
  logic        mem_req_o, frame_err_o, overrun_o, load_done_o, core_rst_no;
  logic [31:0] mem_addr_o, mem_wdata_o;
  logic [15:0] word_count_o;

  int          errors = 0, checks = 0;
  int          gnt_delay = 0, wait_cnt = 0, frame_cnt = 0;
  logic [31:0] held_addr, held_data, next_addr = 32'h0;
  logic [63:0] sb[$];
  logic [63:0] e;

  typedef struct {
    logic [7:0]  b0, b1, b2, b3;
    int          dly;
    logic [31:0] data;
    logic [15:0] cnt;
  } vec_t;

  uart_inst_loader #(.CLKS_PER_BIT(CPB), .BASE_ADDR(32'h0), .IDLE_TIMEOUT_BITS(64)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .uart_rx_i(uart_rx_i), .load_en_i(load_en_i),
    .mem_req_o(mem_req_o), .mem_gnt_i(mem_gnt_i), .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
    .word_count_o(word_count_o), .frame_err_o(frame_err_o), .overrun_o(overrun_o),
    .load_done_o(load_done_o), .core_rst_no(core_rst_no));

  always #5 clk_i = ~clk_i;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Memory model: grants after gnt_delay request cycles, checks hold stability and scoreboard writes.
  always @(negedge clk_i) begin
    if (frame_err_o) frame_cnt++;
    if (!mem_req_o) wait_cnt = 0;
    mem_gnt_i = (wait_cnt >= gnt_delay);
    if (mem_req_o) begin
      if (wait_cnt == 0) begin
        held_addr = mem_addr_o;
        held_data = mem_wdata_o;
      end else begin
        check("hold_addr", mem_addr_o, held_addr);
        check("hold_data", mem_wdata_o, held_data);
      end
      if (mem_gnt_i) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_write: got addr %h data %h expected no write", mem_addr_o, mem_wdata_o);
        end else begin
          e = sb.pop_front();
          check("wr_addr", mem_addr_o, e[63:32]);
          check("wr_data", mem_wdata_o, e[31:0]);
        end
        wait_cnt = 0;
      end else wait_cnt++;
    end
  end

  task automatic push(input logic [31:0] d);
    sb.push_back({next_addr, d});
    next_addr += 32'd4;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    uart_rx_i = 1'b0;
    repeat (CPB) @(negedge clk_i);
    for (int i = 0; i < 8; i++) begin
      uart_rx_i = b[i];
      repeat (CPB) @(negedge clk_i);
    end
    uart_rx_i = stop;
    repeat (CPB) @(negedge clk_i);
    uart_rx_i = 1'b1;
    repeat (2 * CPB) @(negedge clk_i);
  endtask

  task automatic send_word(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2, input logic [7:0] b3);
    send_byte(b0, 1'b1);
    send_byte(b1, 1'b1);
    send_byte(b2, 1'b1);
    send_byte(b3, 1'b1);
  endtask

  task automatic wait_count(input logic [15:0] exp, input int bound);
    for (int i = 0; i < bound && word_count_o !== exp; i++) @(negedge clk_i);
    check("word_count", word_count_o, exp);
  endtask

  task automatic check_reset(input string nm);
    check({nm, "_req"}, mem_req_o, 0);
    check({nm, "_addr"}, mem_addr_o, 32'h0);
    check({nm, "_wdata"}, mem_wdata_o, 32'h0);
    check({nm, "_count"}, word_count_o, 0);
    check({nm, "_frame"}, frame_err_o, 0);
    check({nm, "_overrun"}, overrun_o, 0);
    check({nm, "_done"}, load_done_o, 0);
    check({nm, "_core_rst"}, core_rst_no, 0);
  endtask

  initial begin
    vec_t tbl[4];
    int   f0;
    logic exp_to;
`ifdef INST_LOADER_TIMEOUT_EN
    exp_to = 1'b1;
`else
    exp_to = 1'b0;
`endif
    tbl[0] = '{8'h13, 8'h01, 8'h20, 8'h00, 0, 32'h00200113, 16'd1};
    tbl[1] = '{8'hAA, 8'h55, 8'hF0, 8'h0F, 5, 32'h0FF055AA, 16'd2};
    tbl[2] = '{8'h78, 8'h56, 8'h34, 8'h12, 5, 32'h12345678, 16'd3};
    tbl[3] = '{8'hFF, 8'h00, 8'hFF, 8'h00, 0, 32'h00FF00FF, 16'd4};
    repeat (3) @(negedge clk_i);
    check_reset("por");
    rst_ni = 1'b1;
    repeat (5) @(negedge clk_i);
    for (int i = 0; i < 4; i++) begin
      gnt_delay = tbl[i].dly;
      push(tbl[i].data);
      send_word(tbl[i].b0, tbl[i].b1, tbl[i].b2, tbl[i].b3);
      wait_count(tbl[i].cnt, 300);
    end
    gnt_delay = 0;
    f0 = frame_cnt;
    push(32'h55443311);
    send_byte(8'h11, 1'b1);
    send_byte(8'h22, 1'b0);
    send_byte(8'h33, 1'b1);
    send_byte(8'h44, 1'b1);
    send_byte(8'h55, 1'b1);
    wait_count(16'd5, 300);
    check("frame_pulses", frame_cnt - f0, 1);
    f0 = frame_cnt;
    uart_rx_i = 1'b0;
    repeat (4) @(negedge clk_i);
    uart_rx_i = 1'b1;
    repeat (100) @(negedge clk_i);
    check("glitch_frame", frame_cnt - f0, 0);
    check("glitch_count", word_count_o, 5);
    push(32'h04030201);
    send_word(8'h01, 8'h02, 8'h03, 8'h04);
    wait_count(16'd6, 300);
    check("overrun_clear", overrun_o, 0);
    gnt_delay = 2000;
    push(32'h11223344);
    send_word(8'h44, 8'h33, 8'h22, 8'h11);
    send_word(8'hDD, 8'hCC, 8'hBB, 8'hAA);
    check("overrun_set", overrun_o, 1);
    check("overrun_pending", mem_req_o, 1);
    wait_count(16'd7, 3000);
    gnt_delay = 0;
    repeat (5) @(negedge clk_i);
    send_byte(8'hDE, 1'b1);
    send_byte(8'hAD, 1'b1);
    uart_rx_i = 1'b0;
    repeat (CPB) @(negedge clk_i);
    for (int i = 0; i < 3; i++) begin
      uart_rx_i = (i == 1) ? 1'b1 : 1'b0;
      repeat (CPB) @(negedge clk_i);
    end
    repeat (CPB / 2) @(negedge clk_i);
    rst_ni = 1'b0;
    @(negedge clk_i);
    check_reset("mid_data");
    uart_rx_i = 1'b1;
    repeat (5) @(negedge clk_i);
    rst_ni = 1'b1;
    next_addr = 32'h0;
    repeat (5) @(negedge clk_i);
    push(32'hEFBEADDE);
    send_word(8'hDE, 8'hAD, 8'hBE, 8'hEF);
    wait_count(16'd1, 300);
    repeat (1100) @(negedge clk_i);
    check("idle_done", load_done_o, exp_to);
    check("idle_core_rst", core_rst_no, exp_to);
    load_en_i = 1'b0;
    check("done_same_cycle", load_done_o, exp_to);
    @(negedge clk_i);
    check("done_after_en_low", load_done_o, 1);
    check("core_rst_after_en_low", core_rst_no, 1);
    repeat (20) @(negedge clk_i);
    check("done_sticky", load_done_o, 1);
    check("sb_empty", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "timeout");
  end
endmodule
